// File: rtl/tlp_hdr_gen.sv
// tlp_hdr_gen: builds a PCIe 3DW/4DW TLP header from a request and streams it
// as 32-bit DWs, followed by the payload passed through from pl_* when the
// request carries data.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             header request handshake (ready only when idle)
//   req_fmt/type/tc/td/ep/attr/len  header fields (fmt[2] set -> request rejected)
//   req_id/tag/last_be/first_be     requester fields
//   req_addr                        byte address, bits [1:0] ignored
//   req_err                         one-cycle pulse for a rejected request
//   pl_data/pl_valid/pl_ready       payload DW input stream
//   tx_data/tx_valid/tx_ready       outgoing DW stream
//   tx_sop/tx_eop                   first/last DW of the TLP, qualified by tx_valid
module tlp_hdr_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_fmt,
  input  logic [4:0]  req_type,
  input  logic [2:0]  req_tc,
  input  logic        req_td,
  input  logic        req_ep,
  input  logic [1:0]  req_attr,
  input  logic [9:0]  req_len,
  input  logic [15:0] req_id,
  input  logic [7:0]  req_tag,
  input  logic [3:0]  req_last_be,
  input  logic [3:0]  req_first_be,
  input  logic [63:0] req_addr,
  output logic        req_err,
  input  logic [31:0] pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sop,
  output logic        tx_eop
);

  localparam int unsigned DW_W  = 32;
  localparam int unsigned CNT_W = 11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PLD  = 2'd2;

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(1024);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [1:0]       hdr_idx;
  logic [CNT_W-1:0] pl_cnt;
  logic [DW_W-1:0]  hdr_dw0;
  logic [DW_W-1:0]  hdr_dw1;
  logic [DW_W-1:0]  hdr_dw2;
  logic [DW_W-1:0]  hdr_dw3;
  logic [DW_W-1:0]  hdr_cur;
  logic [DW_W-1:0]  addr_lo;
  logic             is_4dw;
  logic             has_data;
  logic             hdr_last;
  logic             req_acc;

  // fmt lives in the captured DW0, so header shape is read back from there
  assign is_4dw   = hdr_dw0[29];
  assign has_data = hdr_dw0[30];
  assign hdr_last = (hdr_idx == (is_4dw ? 2'd3 : 2'd2));
  assign req_acc  = (state == ST_IDLE) && req_valid && !req_fmt[2];
  assign addr_lo  = req_addr[31:0] & 32'hFFFF_FFFC;

  // Header DW selected by the emit index
  always_comb begin
    hdr_cur = hdr_dw0;
    case (hdr_idx)
      2'd0:    hdr_cur = hdr_dw0;
      2'd1:    hdr_cur = hdr_dw1;
      2'd2:    hdr_cur = hdr_dw2;
      default: hdr_cur = hdr_dw3;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and stream outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_sop    = 1'b0;
    tx_eop    = 1'b0;
    pl_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_acc) begin
          state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_cur;
        tx_sop   = (hdr_idx == 2'd0);
        tx_eop   = hdr_last && !has_data;
        if (tx_ready && hdr_last) begin
          state_nxt = has_data ? ST_PLD : ST_IDLE;
        end
      end
      ST_PLD: begin
        tx_valid = pl_valid;
        tx_data  = pl_data;
        pl_ready = tx_ready;
        tx_eop   = (pl_cnt == CNT_W'(1));
        if (pl_valid && tx_ready && (pl_cnt == CNT_W'(1))) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request capture, header index, payload countdown and error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_idx <= 2'd0;
      pl_cnt  <= '0;
      req_err <= 1'b0;
      hdr_dw0 <= '0;
      hdr_dw1 <= '0;
      hdr_dw2 <= '0;
      hdr_dw3 <= '0;
    end else begin
      req_err <= (state == ST_IDLE) && req_valid && req_fmt[2];
      if (req_acc) begin
        hdr_idx <= 2'd0;
        hdr_dw0 <= {req_fmt, req_type, 1'b0, req_tc, 4'b0000, req_td, req_ep,
                    req_attr, 2'b00, req_len};
        hdr_dw1 <= {req_id, req_tag, req_last_be, req_first_be};
        if (req_fmt[0]) begin
          hdr_dw2 <= req_addr[63:32];
          hdr_dw3 <= addr_lo;
        end else begin
          hdr_dw2 <= addr_lo;
          hdr_dw3 <= '0;
        end
      end else if ((state == ST_HDR) && tx_ready) begin
        if (hdr_last) begin
          hdr_idx <= 2'd0;
          if (has_data) begin
            // a length field of zero means the maximum 1024 DWs
            pl_cnt <= (hdr_dw0[9:0] == 10'd0) ? MAX_LEN : CNT_W'(hdr_dw0[9:0]);
          end
        end else begin
          hdr_idx <= hdr_idx + 2'd1;
        end
      end else if ((state == ST_PLD) && pl_valid && tx_ready) begin
        pl_cnt <= pl_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tlp_hdr_gen.sv
// tb_tlp_hdr_gen: directed bench for tlp_hdr_gen with hand-computed headers.
module tb_tlp_hdr_gen;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [4:0]  req_type;
  logic [2:0]  req_tc;
  logic        req_td;
  logic        req_ep;
  logic [1:0]  req_attr;
  logic [9:0]  req_len;
  logic [15:0] req_id;
  logic [7:0]  req_tag;
  logic [3:0]  req_last_be;
  logic [3:0]  req_first_be;
  logic [63:0] req_addr;
  logic        req_err;
  logic [31:0] pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sop;
  logic        tx_eop;

  tlp_hdr_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_fmt      (req_fmt),
    .req_type     (req_type),
    .req_tc       (req_tc),
    .req_td       (req_td),
    .req_ep       (req_ep),
    .req_attr     (req_attr),
    .req_len      (req_len),
    .req_id       (req_id),
    .req_tag      (req_tag),
    .req_last_be  (req_last_be),
    .req_first_be (req_first_be),
    .req_addr     (req_addr),
    .req_err      (req_err),
    .pl_data      (pl_data),
    .pl_valid     (pl_valid),
    .pl_ready     (pl_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_sop       (tx_sop),
    .tx_eop       (tx_eop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Beat recorder and protocol watchers, all sampled on the falling edge
  int          cyc = 0;
  int          nb = 0;
  int          hold_viol = 0;
  int          mirror_viol = 0;
  logic [31:0] b_data [4096];
  logic        b_sop  [4096];
  logic        b_eop  [4096];
  int          b_cyc  [4096];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_sop = 1'b0;
  logic        prev_eop = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && (!tx_valid || tx_data !== prev_data ||
                         tx_sop !== prev_sop || tx_eop !== prev_eop))
        hold_viol <= hold_viol + 1;
      if ((pl_ready && !tx_ready) || (tx_valid && req_ready))
        mirror_viol <= mirror_viol + 1;
      if (tx_valid && tx_ready && nb < 4096) begin
        b_data[nb] <= tx_data;
        b_sop[nb]  <= tx_sop;
        b_eop[nb]  <= tx_eop;
        b_cyc[nb]  <= cyc;
        nb <= nb + 1;
      end
      prev_stall <= tx_valid && !tx_ready;
      prev_data  <= tx_data;
      prev_sop   <= tx_sop;
      prev_eop   <= tx_eop;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  logic [31:0] pl_mem [1024];

  // Issues one request, feeds payload from pl_mem, applies the requested stalls
  // and compares the recorded beats. Called just after a rising edge.
  task automatic run_tlp(input string name,
                         input logic [2:0] fmt, input logic [4:0] typ, input logic [2:0] tc,
                         input logic td, input logic ep, input logic [1:0] attr,
                         input logic [9:0] len, input logic [15:0] id, input logic [7:0] tag,
                         input logic [3:0] lbe, input logic [3:0] fbe, input logic [63:0] addr,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3,
                         input int txs_len, input int pls_at, input int pls_len,
                         input int abort_at);
    logic [31:0] hdr [4];
    logic [31:0] ev;
    int nh, npl, start, acc, c_now, pl_idx, pls_cnt, guard, nbeats, expn;
    int bad_d, bad_s, bad_e;
    bit first, done, fire_req, fire_pl, fire_eop, accepted;
    hdr[0] = e0; hdr[1] = e1; hdr[2] = e2; hdr[3] = e3;
    nh  = fmt[0] ? 4 : 3;
    npl = fmt[1] ? ((len == 10'd0) ? 1024 : int'(len)) : 0;
    start = nb;
    req_fmt = fmt; req_type = typ; req_tc = tc; req_td = td; req_ep = ep;
    req_attr = attr; req_len = len; req_id = id; req_tag = tag;
    req_last_be = lbe; req_first_be = fbe; req_addr = addr; req_valid = 1'b1;
    tx_ready = 1'b1; pl_valid = 1'b0;
    first = 1'b1; done = 1'b0; accepted = 1'b0;
    acc = 0; pl_idx = 0; pls_cnt = 0; guard = 0;
    while (!done && guard < 3000) begin
      @(negedge clk);
      c_now = cyc;
      if (first) check({name, " req_ready"}, 64'(req_ready), 64'd1);
      first = 1'b0;
      fire_req = req_valid && req_ready;
      fire_pl  = pl_valid && pl_ready;
      fire_eop = tx_valid && tx_ready && tx_eop;
      @(posedge clk); #1;
      guard++;
      if (fire_req) begin
        accepted = 1'b1;
        acc = c_now;
        req_valid = 1'b0;
        req_fmt = ~fmt; req_type = ~typ; req_len = ~len; req_id = ~id;
        req_tag = ~tag; req_addr = ~addr; req_first_be = ~fbe; req_last_be = ~lbe;
      end
      if (fire_pl) pl_idx++;
      if (fire_eop) done = 1'b1;
      pl_data = (pl_idx < 1024) ? pl_mem[pl_idx] : 32'h0;
      if (pl_idx == pls_at && pls_cnt < pls_len) begin
        pl_valid = 1'b0;
        pls_cnt++;
      end else begin
        pl_valid = (pl_idx < npl);
      end
      tx_ready = !(accepted && (cyc - acc) >= 2 && (cyc - acc) <= 1 + txs_len);
      if (abort_at >= 0 && pl_idx == abort_at && !done) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pl_valid = 1'b0;
        @(negedge clk);
        check({name, " abort tx_valid"}, 64'(tx_valid), 64'd0);
        check({name, " abort req_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    check({name, " completed"}, 64'(done), 64'd1);
    pl_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nbeats = nb - start;
    expn = (abort_at >= 0) ? nh + abort_at : nh + npl;
    check({name, " beat count"}, 64'(nbeats), 64'(expn));
    if (nbeats > 0) check({name, " first DW latency"}, 64'(b_cyc[start] - acc), 64'd1);
    bad_d = 0; bad_s = 0; bad_e = 0;
    for (int i = 0; i < nbeats && i < expn; i++) begin
      ev = (i < nh) ? hdr[i] : pl_mem[i - nh];
      if (expn <= 16) begin
        check($sformatf("%s dw%0d data", name, i), 64'(b_data[start + i]), 64'(ev));
        check($sformatf("%s dw%0d sop", name, i), 64'(b_sop[start + i]), 64'(i == 0));
        check($sformatf("%s dw%0d eop", name, i), 64'(b_eop[start + i]),
              64'(i == expn - 1 && abort_at < 0));
      end else begin
        if (b_data[start + i] !== ev) bad_d++;
        if (b_sop[start + i] !== (i == 0)) bad_s++;
        if (b_eop[start + i] !== (i == expn - 1)) bad_e++;
      end
    end
    if (expn > 16) begin
      check({name, " data errors"}, 64'(bad_d), 64'd0);
      check({name, " sop errors"}, 64'(bad_s), 64'd0);
      check({name, " eop errors"}, 64'(bad_e), 64'd0);
    end
    if (txs_len == 0 && pls_len == 0 && abort_at < 0 && nbeats == expn && nbeats > 0)
      check({name, " no bubbles"}, 64'(b_cyc[start + expn - 1] - b_cyc[start]), 64'(expn - 1));
    check({name, " hold violations"}, 64'(hold_viol), 64'd0);
    check({name, " ready violations"}, 64'(mirror_viol), 64'd0);
  endtask

  int start_e;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_fmt = '0; req_type = '0; req_tc = '0;
    req_td = 1'b0; req_ep = 1'b0; req_attr = '0; req_len = '0; req_id = '0;
    req_tag = '0; req_last_be = '0; req_first_be = '0; req_addr = '0;
    pl_data = '0; pl_valid = 1'b0; tx_ready = 1'b1;
    for (int i = 0; i < 1024; i++) pl_mem[i] = 32'h0;

    // reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("rst tx_valid", 64'(tx_valid), 64'd0);
    check("rst tx_sop", 64'(tx_sop), 64'd0);
    check("rst tx_eop", 64'(tx_eop), 64'd0);
    check("rst pl_ready", 64'(pl_ready), 64'd0);
    check("rst req_ready", 64'(req_ready), 64'd1);
    check("rst req_err", 64'(req_err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 3DW memory read
    run_tlp("mrd3", 3'b000, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0100, 8'h05,
            4'h0, 4'hF, 64'h0000_0000_0000_1000,
            32'h0000_0001, 32'h0100_050F, 32'h0000_1000, 32'h0, 0, -1, 0, -1);

    // 4DW memory write with two payload DWs
    pl_mem[0] = 32'h0000_000A; pl_mem[1] = 32'h0000_000B;
    run_tlp("mwr4", 3'b011, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0, 10'd2, 16'h0200, 8'h10,
            4'hF, 4'hF, 64'h0000_0001_0000_0040,
            32'h6000_0002, 32'h0200_10FF, 32'h0000_0001, 32'h0000_0040, 0, -1, 0, -1);

    // backpressure on DW1 and a payload gap; low address bits ignored
    for (int i = 0; i < 4; i++) pl_mem[i] = 32'hC000_0000 + i;
    run_tlp("bp", 3'b010, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0, 10'd4, 16'h1234, 8'h22,
            4'hF, 4'hF, 64'h0000_0000_2000_0107,
            32'h4000_0004, 32'h1234_22FF, 32'h2000_0104, 32'h0, 3, 2, 2, -1);

    // len=0 means 1024 payload DWs; tc/td/attr fields placed in DW0
    for (int i = 0; i < 1024; i++) pl_mem[i] = 32'hD000_0000 + i;
    run_tlp("len1024", 3'b010, 5'd0, 3'b101, 1'b1, 1'b0, 2'b10, 10'd0, 16'hABCD, 8'h7F,
            4'hF, 4'hF, 64'h0000_0000_8000_0000,
            32'h4050_A000, 32'hABCD_7FFF, 32'h8000_0000, 32'h0, 0, -1, 0, -1);

    // reset while payload DW 5 of 8 is presented, then a clean TLP
    for (int i = 0; i < 8; i++) pl_mem[i] = 32'hE000_0000 + i;
    run_tlp("abort", 3'b010, 5'd0, 3'd0, 1'b0, 1'b1, 2'd0, 10'd8, 16'h0001, 8'h09,
            4'hF, 4'hF, 64'h0000_0000_0000_0300,
            32'h4000_4008, 32'h0001_09FF, 32'h0000_0300, 32'h0, 0, -1, 0, 4);
    run_tlp("post-abort", 3'b000, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0100, 8'h05,
            4'h0, 4'hF, 64'h0000_0000_0000_1000,
            32'h0000_0001, 32'h0100_050F, 32'h0000_1000, 32'h0, 0, -1, 0, -1);

    // prefix fmt rejected with a single req_err pulse
    start_e = nb;
    req_fmt = 3'b100; req_len = 10'd1; req_valid = 1'b1;
    @(negedge clk);
    check("err req_ready", 64'(req_ready), 64'd1);
    check("err pulse early", 64'(req_err), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_fmt = 3'b000;
    @(negedge clk);
    check("err pulse", 64'(req_err), 64'd1);
    check("err tx_valid", 64'(tx_valid), 64'd0);
    check("err req_ready after", 64'(req_ready), 64'd1);
    @(negedge clk);
    check("err pulse width", 64'(req_err), 64'd0);
    check("err tx_valid later", 64'(tx_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("err no beats", 64'(nb - start_e), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
